// File: rtl/control_sequencer_if.sv
// Bus-control bundle between the control sequencer and the CPU datapath.
// The sequencer uses the master side; the datapath (or a bench) uses the slave side.
interface control_sequencer_if;
  logic [3:0] instruction;
  logic       pc_inc;
  logic       pc_out;
  logic       pc_in;
  logic       mar_in;
  logic       ram_out;
  logic       ram_in;
  logic       ir_in;
  logic       ir_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       alu_out;
  logic       alu_sub;
  logic       out_in;
  logic       halt;
  logic [2:0] t_state;

  modport master (
    input  instruction,
    output pc_inc, pc_out, pc_in, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, out_in, halt, t_state
  );

  modport slave (
    output instruction,
    input  pc_inc, pc_out, pc_in, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, out_in, halt, t_state
  );
endinterface

// File: rtl/control_sequencer.sv
// T-state control sequencer for the 8-bit bus CPU: fetch, decode, execute, halt.
// Strobes are decoded combinationally from the current T-state and opcode.
module control_sequencer (
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state;
  state_t state_next;

  logic pc_inc_c, pc_out_c, pc_in_c, mar_in_c, ram_out_c, ram_in_c;
  logic ir_in_c, ir_out_c, a_in_c, a_out_c, b_in_c;
  logic alu_out_c, alu_sub_c, out_in_c, halt_c;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= T1;
    else        state <= state_next;
  end

  // Microprogram: next state and strobes for the current T-state/opcode.
  always_comb begin
    state_next = T1;
    pc_inc_c   = 1'b0;
    pc_out_c   = 1'b0;
    pc_in_c    = 1'b0;
    mar_in_c   = 1'b0;
    ram_out_c  = 1'b0;
    ram_in_c   = 1'b0;
    ir_in_c    = 1'b0;
    ir_out_c   = 1'b0;
    a_in_c     = 1'b0;
    a_out_c    = 1'b0;
    b_in_c     = 1'b0;
    alu_out_c  = 1'b0;
    alu_sub_c  = 1'b0;
    out_in_c   = 1'b0;
    halt_c     = 1'b0;

    case (state)
      T1: begin
        pc_out_c   = 1'b1;
        mar_in_c   = 1'b1;
        state_next = T2;
      end
      T2: begin
        ram_out_c  = 1'b1;
        ir_in_c    = 1'b1;
        pc_inc_c   = 1'b1;
        state_next = T3;
      end
      T3: begin
        case (bus.instruction)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_out_c   = 1'b1;
            mar_in_c   = 1'b1;
            state_next = T4;
          end
          OP_LDI: begin
            ir_out_c = 1'b1;
            a_in_c   = 1'b1;
          end
          OP_JMP: begin
            ir_out_c = 1'b1;
            pc_in_c  = 1'b1;
          end
          OP_OUT: begin
            a_out_c  = 1'b1;
            out_in_c = 1'b1;
          end
          OP_HLT:  state_next = HALT;
          default: state_next = T1;
        endcase
      end
      T4: begin
        case (bus.instruction)
          OP_LDA: begin
            ram_out_c = 1'b1;
            a_in_c    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_out_c  = 1'b1;
            b_in_c     = 1'b1;
            state_next = T5;
          end
          OP_STA: begin
            a_out_c  = 1'b1;
            ram_in_c = 1'b1;
          end
          default: state_next = T1;
        endcase
      end
      T5: begin
        if (bus.instruction == OP_ADD || bus.instruction == OP_SUB) begin
          alu_out_c = 1'b1;
          a_in_c    = 1'b1;
          alu_sub_c = (bus.instruction == OP_SUB);
        end
      end
      HALT: begin
        halt_c     = 1'b1;
        state_next = HALT;
      end
      default: state_next = T1;
    endcase
  end

  // Strobes are masked while clear is low so nothing leaks during reset.
  assign bus.pc_inc  = pc_inc_c  & clear;
  assign bus.pc_out  = pc_out_c  & clear;
  assign bus.pc_in   = pc_in_c   & clear;
  assign bus.mar_in  = mar_in_c  & clear;
  assign bus.ram_out = ram_out_c & clear;
  assign bus.ram_in  = ram_in_c  & clear;
  assign bus.ir_in   = ir_in_c   & clear;
  assign bus.ir_out  = ir_out_c  & clear;
  assign bus.a_in    = a_in_c    & clear;
  assign bus.a_out   = a_out_c   & clear;
  assign bus.b_in    = b_in_c    & clear;
  assign bus.alu_out = alu_out_c & clear;
  assign bus.alu_sub = alu_sub_c & clear;
  assign bus.out_in  = out_in_c  & clear;
  assign bus.halt    = halt_c    & clear;
  assign bus.t_state = 3'(state);
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed opcode scenarios plus a
// random opcode stream checked against a per-instruction micro-step table.
module tb_control_sequencer;
  localparam int unsigned PC_INC  = 14;
  localparam int unsigned PC_OUT  = 13;
  localparam int unsigned PC_IN   = 12;
  localparam int unsigned MAR_IN  = 11;
  localparam int unsigned RAM_OUT = 10;
  localparam int unsigned RAM_IN  = 9;
  localparam int unsigned IR_IN   = 8;
  localparam int unsigned IR_OUT  = 7;
  localparam int unsigned A_IN    = 6;
  localparam int unsigned A_OUT   = 5;
  localparam int unsigned B_IN    = 4;
  localparam int unsigned ALU_OUT = 3;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned OUT_IN  = 1;
  localparam int unsigned HALT_B  = 0;
  localparam logic [14:0] HALT_VEC = 15'd1;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] instr = 4'd0;
  int         total = 0;
  int         bad   = 0;

  control_sequencer_if bus();
  assign bus.instruction = instr;

  control_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;

  logic [14:0] obs;
  assign obs = {bus.pc_inc, bus.pc_out, bus.pc_in, bus.mar_in, bus.ram_out,
                bus.ram_in, bus.ir_in, bus.ir_out, bus.a_in, bus.a_out,
                bus.b_in, bus.alu_out, bus.alu_sub, bus.out_in, bus.halt};

  // Instruction length in cycles from T1 to the next T1 (HLT: cycles to reach HALT).
  function automatic int exp_len(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd3) return 4;
    if (op == 4'd1 || op == 4'd2) return 5;
    return 3;
  endfunction

  // Expected strobe set for micro-step 'step' (0 = T1) of opcode 'op'.
  function automatic logic [14:0] exp_vec(input logic [3:0] op, input int step);
    logic [14:0] v;
    v = '0;
    if (step == 0) begin
      v[PC_OUT] = 1'b1; v[MAR_IN] = 1'b1;
    end else if (step == 1) begin
      v[RAM_OUT] = 1'b1; v[IR_IN] = 1'b1; v[PC_INC] = 1'b1;
    end else if (step == 2) begin
      if (op <= 4'd3)      begin v[IR_OUT] = 1'b1; v[MAR_IN] = 1'b1; end
      else if (op == 4'd4) begin v[IR_OUT] = 1'b1; v[A_IN] = 1'b1; end
      else if (op == 4'd5) begin v[IR_OUT] = 1'b1; v[PC_IN] = 1'b1; end
      else if (op == 4'd14) begin v[A_OUT] = 1'b1; v[OUT_IN] = 1'b1; end
    end else if (step == 3) begin
      if (op == 4'd0)      begin v[RAM_OUT] = 1'b1; v[A_IN] = 1'b1; end
      else if (op == 4'd3) begin v[A_OUT] = 1'b1; v[RAM_IN] = 1'b1; end
      else                 begin v[RAM_OUT] = 1'b1; v[B_IN] = 1'b1; end
    end else begin
      v[ALU_OUT] = 1'b1; v[A_IN] = 1'b1; v[ALU_SUB] = (op == 4'd2);
    end
    return v;
  endfunction

  task automatic test_reset();
    instr = 4'b0001;
    clear = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      total++; if (bus.t_state !== 3'd0) begin bad++; $display("FAIL reset_tstate: got %0d want 0", bus.t_state); end
      total++; if (obs !== 15'd0) begin bad++; $display("FAIL reset_strobes: got %h want 0", obs); end
    end
    @(negedge clock); clear = 1'b1; #1;
    total++; if (obs !== exp_vec(4'd0, 0)) begin bad++; $display("FAIL release_t1: got %h want %h", obs, exp_vec(4'd0, 0)); end
    total++; if (bus.t_state !== 3'd0) begin bad++; $display("FAIL release_tstate: got %0d want 0", bus.t_state); end
    @(negedge clock); #1;
    total++; if (bus.t_state !== 3'd1) begin bad++; $display("FAIL first_edge_tstate: got %0d want 1", bus.t_state); end
    clear = 1'b0;
    @(negedge clock); clear = 1'b1;
  endtask

  task automatic test_lda_sta();
    logic [3:0] ops [2];
    ops[0] = 4'd0; ops[1] = 4'd3;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s <= exp_len(ops[k]); s++) begin
        instr = ops[k]; #1;
        total++; if (bus.t_state !== 3'((s == exp_len(ops[k])) ? 0 : s)) begin bad++; $display("FAIL ldsta_tstate op=%0d s=%0d: got %0d", ops[k], s, bus.t_state); end
        if (s < exp_len(ops[k])) begin
          total++; if (obs !== exp_vec(ops[k], s)) begin bad++; $display("FAIL ldsta_strobes op=%0d s=%0d: got %h want %h", ops[k], s, obs, exp_vec(ops[k], s)); end
          @(negedge clock);
        end
      end
    end
  endtask

  task automatic test_add_sub();
    for (int k = 1; k <= 2; k++) begin
      for (int s = 0; s < 5; s++) begin
        instr = 4'(k); #1;
        total++; if (bus.t_state !== 3'(s)) begin bad++; $display("FAIL addsub_tstate op=%0d s=%0d: got %0d want %0d", k, s, bus.t_state, s); end
        total++; if (obs !== exp_vec(4'(k), s)) begin bad++; $display("FAIL addsub_strobes op=%0d s=%0d: got %h want %h", k, s, obs, exp_vec(4'(k), s)); end
        total++; if (bus.alu_sub !== (k == 2 && s == 4)) begin bad++; $display("FAIL addsub_alu_sub op=%0d s=%0d: got %b", k, s, bus.alu_sub); end
        @(negedge clock);
      end
      #1;
      total++; if (bus.t_state !== 3'd0) begin bad++; $display("FAIL addsub_return: got %0d want 0", bus.t_state); end
    end
  endtask

  task automatic test_short_ops();
    logic [3:0] ops [4];
    ops[0] = 4'd4; ops[1] = 4'd5; ops[2] = 4'd14; ops[3] = 4'd10;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        instr = ops[k]; #1;
        total++; if (bus.t_state !== 3'(s)) begin bad++; $display("FAIL short_tstate op=%0d s=%0d: got %0d", ops[k], s, bus.t_state); end
        total++; if (obs !== exp_vec(ops[k], s)) begin bad++; $display("FAIL short_strobes op=%0d s=%0d: got %h want %h", ops[k], s, obs, exp_vec(ops[k], s)); end
        total++; if (bus.pc_in !== (ops[k] == 4'd5 && s == 2)) begin bad++; $display("FAIL short_pc_in op=%0d s=%0d: got %b", ops[k], s, bus.pc_in); end
        @(negedge clock);
      end
      #1;
      total++; if (bus.t_state !== 3'd0) begin bad++; $display("FAIL short_return op=%0d: got %0d want 0", ops[k], bus.t_state); end
    end
  endtask

  task automatic test_hlt();
    for (int s = 0; s < 3; s++) begin
      instr = 4'hF; #1;
      total++; if (obs !== exp_vec(4'hF, s)) begin bad++; $display("FAIL hlt_strobes s=%0d: got %h want %h", s, obs, exp_vec(4'hF, s)); end
      @(negedge clock);
    end
    for (int c = 0; c < 12; c++) begin
      instr = 4'($urandom); #1;
      total++; if (bus.t_state !== 3'd7) begin bad++; $display("FAIL halt_tstate c=%0d: got %0d want 7", c, bus.t_state); end
      total++; if (obs !== HALT_VEC || bus.halt !== 1'b1) begin bad++; $display("FAIL halt_strobes c=%0d: got %h want %h", c, obs, HALT_VEC); end
      @(negedge clock);
    end
    #2; clear = 1'b0; #1;
    total++; if (bus.t_state !== 3'd0) begin bad++; $display("FAIL halt_clear_tstate: got %0d want 0", bus.t_state); end
    total++; if (obs !== 15'd0 || bus.halt !== 1'b0) begin bad++; $display("FAIL halt_clear_strobes: got %h want 0", obs); end
    @(negedge clock); clear = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] op;
    int         len;
    for (int n = 0; n < 1000; n++) begin
      op  = 4'($urandom_range(0, 15));
      len = exp_len(op);
      for (int s = 0; s < len; s++) begin
        instr = (s < 2) ? 4'($urandom) : op; #1;
        total++; if (bus.t_state !== 3'(s)) begin bad++; $display("FAIL rand_tstate n=%0d op=%0d s=%0d: got %0d", n, op, s, bus.t_state); end
        total++; if (obs !== exp_vec(op, s)) begin bad++; $display("FAIL rand_strobes n=%0d op=%0d s=%0d: got %h want %h", n, op, s, obs, exp_vec(op, s)); end
        total++; if ($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out}) > 1) begin bad++; $display("FAIL rand_bus_excl n=%0d s=%0d: got %h want at most one driver", n, s, obs); end
        total++; if (bus.ir_in === 1'b1 && bus.t_state !== 3'd1) begin bad++; $display("FAIL rand_ir_in n=%0d: got ir_in=1 in t_state %0d want t_state 1", n, bus.t_state); end
        if (s < 2) begin
          instr = ~instr; #1;
          total++; if (obs !== exp_vec(op, s)) begin bad++; $display("FAIL rand_fetch_toggle n=%0d s=%0d: got %h want %h", n, s, obs, exp_vec(op, s)); end
        end
        @(negedge clock);
      end
      if (op == 4'hF) begin
        #1;
        total++; if (bus.t_state !== 3'd7 || obs !== HALT_VEC) begin bad++; $display("FAIL rand_halt n=%0d: got t=%0d %h want t=7 %h", n, bus.t_state, obs, HALT_VEC); end
        clear = 1'b0;
        @(negedge clock); clear = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_sta();
    test_add_sub();
    test_short_ops();
    test_hlt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
